// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
//
// Shares the single Data Memory port between two requesters that use the
// req/gnt/rvalid protocol. Requester 0 is the core LSU. Requester 1 is the
// debug/test-loader port.
//
// The address phase is a combinational round-robin mux with no added latency.
// Once a request has been presented without a grant, the selection is locked
// so that the address phase stays stable until that request is granted.
// Each accepted transaction pushes its requester ID into an in-order FIFO.
// Each data_rvalid_i pops the FIFO and is steered back to the requester that
// issued the transaction.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   m_req_i[1:0]    per-requester request (bit k = requester k)
//   m_we_i[1:0]     per-requester write enable
//   m_addr_i        per-requester address, requester k at [32k+31:32k]
//   m_be_i          per-requester byte enables, requester k at [4k+3:4k]
//   m_wdata_i       per-requester write data, requester k at [32k+31:32k]
//   m_gnt_o[1:0]    per-requester grant
//   m_rvalid_o[1:0] per-requester response valid (reads and writes)
//   m_rdata_o       read data broadcast to both requesters
//   data_*_o        request side of the Data Memory port
//   data_gnt_i      Data Memory grant
//   data_rvalid_i   Data Memory response valid (in order)
//   data_rdata_i    Data Memory read data
//   err_o           sticky protocol error flag: stray response, or a locked
//                   request that was withdrawn
// ---------------------------------------------------------------------------
module data_mem_arbiter #(
    parameter int MAX_OUTST = 2,   // FIFO depth, 1..8
    parameter int ADDR_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            m_req_i,
    input  logic [1:0]            m_we_i,
    input  logic [2*ADDR_W-1:0]   m_addr_i,
    input  logic [7:0]            m_be_i,
    input  logic [2*ADDR_W-1:0]   m_wdata_i,
    output logic [1:0]            m_gnt_o,
    output logic [1:0]            m_rvalid_o,
    output logic [ADDR_W-1:0]     m_rdata_o,
    output logic                  data_req_o,
    output logic                  data_we_o,
    output logic [ADDR_W-1:0]     data_addr_o,
    output logic [3:0]            data_be_o,
    output logic [ADDR_W-1:0]     data_wdata_o,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    input  logic [ADDR_W-1:0]     data_rdata_i,
    output logic                  err_o
);

    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    // Registered state
    logic             prio;        // requester favoured when both request
    logic             lock_valid;  // a request is waiting for its grant
    logic             lock_id;     // requester held by the lock
    logic             err;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_id [MAX_OUTST];

    // Combinational decode
    logic sel;
    logic full;
    logic empty;
    logic lock_drop;
    logic req;
    logic hs;
    logic pop;
    logic head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // NOTE: every signal gets a default at the top of the always_comb so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        full      = (count == CNT_W'(MAX_OUTST));
        empty     = (count == '0);
        lock_drop = lock_valid && !m_req_i[lock_id];

        if (lock_valid)
            sel = lock_id;
        else if (&m_req_i)
            sel = prio;
        else
            sel = m_req_i[1];

        // A withdrawn locked request is dropped for one cycle. Arbitration
        // resumes from the unlocked state on the following cycle. The
        // outputs are gated by rst_n so that all of them read 0 while reset
        // is asserted.
        req  = rst_n && (|m_req_i) && !full && !lock_drop;
        hs   = req && data_gnt_i;
        head = fifo_id[rd_ptr];
        pop  = rst_n && data_rvalid_i && !empty;
    end

    always_comb begin
        data_req_o   = req;
        data_we_o    = 1'b0;
        data_addr_o  = '0;
        data_be_o    = '0;
        data_wdata_o = '0;
        if (req) begin
            if (sel) begin
                data_we_o    = m_we_i[1];
                data_addr_o  = m_addr_i[2*ADDR_W-1:ADDR_W];
                data_be_o    = m_be_i[7:4];
                data_wdata_o = m_wdata_i[2*ADDR_W-1:ADDR_W];
            end else begin
                data_we_o    = m_we_i[0];
                data_addr_o  = m_addr_i[ADDR_W-1:0];
                data_be_o    = m_be_i[3:0];
                data_wdata_o = m_wdata_i[ADDR_W-1:0];
            end
        end

        m_gnt_o    = sel  ? {hs, 1'b0}  : {1'b0, hs};
        m_rvalid_o = head ? {pop, 1'b0} : {1'b0, pop};
        m_rdata_o  = rst_n ? data_rdata_i : '0;
        err_o      = err;
    end

    // NOTE: state registers use non-blocking assignments so that every
    // always_ff samples pre-edge values, which gives order-independent
    // simulation that matches the flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio       <= 1'b0;
            lock_valid <= 1'b0;
            lock_id    <= 1'b0;
            err        <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            if (hs) begin
                prio   <= ~sel;
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);

            case ({hs, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            // The lock holds sel stable across a stalled address phase.
            // Because req is qualified by !lock_drop, "req without hs"
            // means the request was presented and not granted.
            if (hs || lock_drop) begin
                lock_valid <= 1'b0;
            end else if (req) begin
                lock_valid <= 1'b1;
                lock_id    <= sel;
            end

            if (lock_drop || (data_rvalid_i && empty))
                err <= 1'b1;
        end
    end

    // NOTE: the ID storage has no reset. Entries are only read behind the
    // count, which is reset, so clearing the array would add reset fan-out
    // and nothing else.
    always_ff @(posedge clk) begin
        if (hs)
            fifo_id[wr_ptr] <= sel;
    end

endmodule
